// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and format codes for the immediate decode stage.
// U/J decode is controlled by the IMM_GEN_UJ_EN macro in imm_gen_decode.
package imm_gen_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_e;

endpackage

// File: rtl/imm_gen_decode.sv
// Combinational RV32I/RV64I immediate extractor (XLEN = 32 or 64).
// U and J formats are only built when IMM_GEN_UJ_EN is defined.
module imm_gen_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o
);

  // Every immediate fits a signed 32-bit value; widen once at the end.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [6:0] opcode;
  logic [5:0] shamt;
  logic       shift_ok;
  logic       unused_bits;

  assign opcode      = instr_i[6:0];
  assign unused_bits = ^{instr_i[14], instr_i[19:15]};

  if (XLEN == 64) begin : g_rv64
    assign shamt    = instr_i[25:20];
    assign shift_ok = (instr_i[31:26] == 6'b000000) | (instr_i[31:26] == 6'b010000);
  end else begin : g_rv32
    assign shamt    = {1'b0, instr_i[24:20]};
    assign shift_ok = (instr_i[31:25] == 7'b0000000) | (instr_i[31:25] == 7'b0100000);
  end

  always_comb begin
    imm_o     = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: begin
        if ((opcode == OP_IMM) && (instr_i[13:12] == 2'b01)) begin
          imm_o     = XLEN'(shamt);
          fmt_o     = FMT_SHAMT;
          illegal_o = ~shift_ok;
        end else begin
          imm_o = sext32({{20{instr_i[31]}}, instr_i[31:20]});
          fmt_o = FMT_I;
        end
      end
      OP_STORE: begin
        imm_o = sext32({{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]});
        fmt_o = FMT_S;
      end
      OP_BRANCH: begin
        imm_o = sext32({{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0});
        fmt_o = FMT_B;
      end
`ifdef IMM_GEN_UJ_EN
      OP_LUI, OP_AUIPC: begin
        imm_o = sext32({instr_i[31:12], 12'b0});
        fmt_o = FMT_U;
      end
      OP_JAL: begin
        imm_o = sext32({{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0});
        fmt_o = FMT_J;
      end
`endif
      OP_REG: begin
        illegal_o = 1'b0;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate decode stage: valid/ready handshake, 2-entry skid,
// flush and handshake counter. U/J decode follows IMM_GEN_UJ_EN.
module imm_decode_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             imm_valid_o,
  input  logic             imm_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [15:0]      dec_count_o
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t      out_q, out_d, skid_q, skid_d, new_entry;
  logic        out_valid_q, out_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic        in_hs, out_hs, out_drain;

  imm_gen_decode #(.XLEN(XLEN)) u_decode (
    .instr_i   (instr_i),
    .imm_o     (new_entry.imm),
    .fmt_o     (new_entry.fmt),
    .illegal_o (new_entry.illegal)
  );
  assign new_entry.tag = tag_i;

  assign instr_ready_o = ~skid_valid_q & rst_i;
  assign in_hs         = instr_valid_i & instr_ready_o;
  assign out_hs        = out_valid_q & imm_ready_i;
  assign out_drain     = ~out_valid_q | out_hs;

  // SKID is only ever filled while OUT is stalled, so it always holds the younger entry.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q + 16'(out_hs);
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_drain) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_hs) begin
        out_d       = new_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_hs) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign imm_valid_o = out_valid_q;
  assign imm_o       = out_q.imm;
  assign fmt_o       = out_q.fmt;
  assign illegal_o   = out_q.illegal;
  assign tag_o       = out_q.tag;
  assign dec_count_o = cnt_q;

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised immediate decoder sitting between the IF/ID pipeline register and the ID-stage operand mux. It covers all RV32I/RV64I immediate formats, including correct shift-amount handling and byte-offset branch and jump immediates. Each decoded result is registered behind a valid/ready handshake with a 2-entry skid buffer, so ID back-pressure never drops an instruction. A flush input supports branch/hazard recovery, and a wrap-around counter reports decoded-instruction statistics.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values are 32 and 64 only.
- TAG_W, 8: width of the sideband tag (PC bits or a sequence id), passed through unchanged.

Ports:
- clk_i, input, 1: single clock; all state updates on the rising edge.
- rst_i, input, 1: reset, synchronous, active-low.
- flush_i, input, 1: discards all held and in-flight entries.
- instr_valid_i, input, 1: an instruction is offered.
- instr_ready_o, output, 1: the block can accept an instruction this cycle.
- instr_i, input, 32: raw instruction.
- tag_i, input, TAG_W: sideband tag for the instruction.
- imm_valid_o, output, 1: a decoded result is presented.
- imm_ready_i, input, 1: the consumer takes the result this cycle.
- imm_o, output, XLEN: sign- or zero-extended immediate.
- fmt_o, output, 3: format code.
- illegal_o, output, 1: unsupported opcode or malformed shift encoding.
- tag_o, output, TAG_W: tag travelling with the result.
- dec_count_o, output, 16: count of output handshakes.

## Operation
Decode, by opcode:
- I-format: 0010011, 0000011, 1100111.
- Shift (funct3 001/101 under 0010011):
  - imm_o is zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - illegal_o=1 unless the upper funct bits are all zero, or have only bit 30 set.
  - fmt_o=SHAMT.
- S-format: 0100011.
- B-format: 1100011. Output is a byte offset: bit0=0, imm[12:1] taken from the instruction, sign-extended from bit 12.
- U-format: 0110111, 0010111. Output is instr[31:12]<<12, sign-extended to XLEN.
- J-format: 1101111. Output is a byte offset with bit0=0, sign-extended from bit 20.
- R-format (0110011): imm_o=0, fmt_o=NONE, illegal_o=0.
- Any other opcode: imm_o=0, fmt_o=NONE, illegal_o=1.

Sign extension is always from the format's top immediate bit to XLEN.

Buffering:
- Two registers: OUT (drives the outputs) and SKID. Each holds {imm, fmt, illegal, tag} plus a valid bit.
- Input handshake: instr_valid_i & instr_ready_o.
- Output handshake: imm_valid_o & imm_ready_i.
- instr_ready_o = ~SKID.valid & rst_i.
- On an accepted input:
  - If OUT is empty or draining this cycle, the entry loads into OUT.
  - Otherwise it loads into SKID.
- When OUT drains and SKID is valid, SKID moves to OUT and SKID empties.
- Order is strictly FIFO.

Flush:
- flush_i=1 clears both valid bits at the next edge.
- Overrides an input handshake in the same cycle: the accepted entry is dropped.
- An output handshake in the same cycle still counts.

Counter:
- dec_count_o increments on each output handshake and wraps 0xFFFF→0x0000.
- Cleared only by reset, never by flush.

## Timing
- Latency: 1 cycle from accept to imm_valid_o when OUT is empty.
- Throughput: 1 instruction per cycle while imm_ready_i=1.
- Stall: after OUT and SKID fill, instr_ready_o is low from the next cycle onward. It rises in the cycle after the first output handshake.
- While rst_i=0 the registers clear at the edge and instr_ready_o=0. At the first edge with rst_i=0, every output goes to 0: imm_valid_o, imm_o, fmt_o, illegal_o, tag_o, dec_count_o.
- Reset asserted mid-stall discards all entries. instr_ready_o=1 in the first cycle after rst_i returns high.
- imm_o/fmt_o/illegal_o/tag_o hold stable while imm_valid_o=1 and imm_ready_i=0.

## Configuration
- IMM_GEN_UJ_EN defined: U and J formats are decoded as above.
- IMM_GEN_UJ_EN undefined:
  - Opcodes 0110111, 0010111 and 1101111 produce imm_o=0, fmt_o=NONE, illegal_o=1.
  - The U/J decode logic is not synthesised.

## Structure
- Package imm_gen_pkg holds:
  - opcode constants: OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG;
  - format codes: NONE=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6.
- Sub-module imm_gen_decode: purely combinational, parametrised by XLEN, instantiated once.
- imm_decode_stage itself holds only the handshake, skid, flush and counter logic.

## Test plan
- addi, 0xFFF00093 → one cycle later imm_o=0xFFFFFFFF, fmt_o=I, illegal_o=0.
- srai, 0x4030D093 → imm_o=0x3, fmt_o=SHAMT, illegal_o=0. Variant 0xFE30D093 → illegal_o=1.
- beq -4, 0xFE000EE3 → imm_o=0xFFFFFFFC, fmt_o=B. sw, 0x0020A423 → imm_o=0x8, fmt_o=S.
- lui, 0x123450B7:
  - with IMM_GEN_UJ_EN → imm_o=0x12345000, fmt_o=U;
  - without it → fmt_o=NONE, illegal_o=1;
  - with XLEN=64 and 0x800000B7 → imm_o=0xFFFFFFFF80000000.
- Back-pressure:
  - hold imm_ready_i=0 and offer tags 1, 2, 3;
  - tags 1 and 2 are accepted, instr_ready_o=0 from the cycle after tag 2 is accepted, tag 3 is held;
  - release imm_ready_i → tags out in order 1, 2, 3 and dec_count_o advances by 3.
- Flush with OUT and SKID full, plus flush asserted alongside an input handshake → next cycle imm_valid_o=0, instr_ready_o=1, dec_count_o unchanged. dec_count_o wraps 0xFFFF→0x0000 after 65536 handshakes.
